// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// ---------------------------------------------------------------------------
// Operand forwarding and latency-scoreboard hazard unit for the integer
// pipeline. Sits between decode/issue and EX.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   rd_en        per read port: port uses a register operand
//   rd_addr      per read port source register (slice p)
//   fwd_we       per forwarding stage: stage holds a valid register write
//   fwd_addr     per forwarding stage destination register (slice k)
//   issue_valid  an instruction with a register destination is issuing
//   issue_rd     destination of the issuing instruction
//   issue_lat    cycles until its result is forwardable (0 = single cycle)
//   flush        discard every pending scoreboard entry
//   sel          per read port mux select: 0 = regfile, k+1 = stage k
//   stall        hold issue this cycle
//   stall_cnt    saturating count of stalled cycles since reset
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int REG_BITS = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_FWD  = 2,
    parameter int LAT_BITS = 3,
    parameter int SEL_BITS = $clog2(NUM_FWD + 1),
    parameter int CNT_BITS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*REG_BITS-1:0]   rd_addr,
    input  logic [NUM_FWD-1:0]           fwd_we,
    input  logic [NUM_FWD*REG_BITS-1:0]  fwd_addr,
    input  logic                         issue_valid,
    input  logic [REG_BITS-1:0]          issue_rd,
    input  logic [LAT_BITS-1:0]          issue_lat,
    input  logic                         flush,
    output logic [NUM_RD*SEL_BITS-1:0]   sel,
    output logic                         stall,
    output logic [CNT_BITS-1:0]          stall_cnt
);

    localparam int NUM_REGS = 1 << REG_BITS;

    logic [LAT_BITS-1:0] busy_cnt_r [NUM_REGS];
    logic [NUM_REGS-1:0] busy_s;
    logic [NUM_RD*SEL_BITS-1:0] sel_s;
    logic                stall_s;
    logic                accept_s;
    logic [CNT_BITS-1:0] stall_cnt_r;

    // Forwarding select: scan oldest to youngest so the youngest match is the last write.
    always_comb begin
        logic [REG_BITS-1:0] src_s;
        logic [SEL_BITS-1:0] pick_s;
        sel_s  = '0;
        src_s  = '0;
        pick_s = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            src_s  = rd_addr[p*REG_BITS +: REG_BITS];
            pick_s = '0;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_we[k] && (fwd_addr[k*REG_BITS +: REG_BITS] == src_s)) begin
                    pick_s = SEL_BITS'(k + 1);
                end else begin
                    pick_s = pick_s;
                end
            end
            // x0 is hardwired zero, so it always comes from the register file.
            if (rd_en[p] && (src_s != '0)) begin
                sel_s[p*SEL_BITS +: SEL_BITS] = pick_s;
            end else begin
                sel_s[p*SEL_BITS +: SEL_BITS] = '0;
            end
        end
    end

    // Busy flags derived from the latency counters; x0 is never busy.
    always_comb begin
        busy_s = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_s[r] = (busy_cnt_r[r] != '0);
        end
    end

    // Stall when any active read port sources a busy register.
    always_comb begin
        logic [REG_BITS-1:0] src_s;
        stall_s = 1'b0;
        src_s   = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            src_s = rd_addr[p*REG_BITS +: REG_BITS];
            if (rd_en[p] && (src_s != '0) && busy_s[src_s]) begin
                stall_s = 1'b1;
            end else begin
                stall_s = stall_s;
            end
        end
    end

    assign accept_s = issue_valid & ~stall_s;

    // Latency scoreboard: clear on reset/flush, reload on accepted issue, else count down.
    always_ff @(posedge clk) begin
        busy_cnt_r[0] <= '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (rst || flush) begin
                busy_cnt_r[r] <= '0;
            end else if (accept_s && (issue_rd == REG_BITS'(r))) begin
                // A younger producer overwrites any pending count (WAW).
                busy_cnt_r[r] <= issue_lat;
            end else if (busy_cnt_r[r] != '0) begin
                busy_cnt_r[r] <= busy_cnt_r[r] - LAT_BITS'(1);
            end else begin
                busy_cnt_r[r] <= busy_cnt_r[r];
            end
        end
    end

    // Saturating stall-cycle counter; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (stall_s && (stall_cnt_r != {CNT_BITS{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_BITS'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Forwarding selects and stall feed the same-cycle EX muxes and issue logic.
    assign sel       = sel_s;
    assign stall     = stall_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed vectors, expected values queued by
// the stimulus and compared by an independent negedge monitor.
module tb_fwd_hazard_unit;

    localparam int REG_BITS = 5;
    localparam int NUM_RD   = 2;
    localparam int NUM_FWD  = 2;
    localparam int LAT_BITS = 3;
    localparam int SEL_BITS = 2;
    localparam int CNT_BITS = 4;

    logic                        clk;
    logic                        rst;
    logic [NUM_RD-1:0]           rd_en;
    logic [NUM_RD*REG_BITS-1:0]  rd_addr;
    logic [NUM_FWD-1:0]          fwd_we;
    logic [NUM_FWD*REG_BITS-1:0] fwd_addr;
    logic                        issue_valid;
    logic [REG_BITS-1:0]         issue_rd;
    logic [LAT_BITS-1:0]         issue_lat;
    logic                        flush;
    logic [NUM_RD*SEL_BITS-1:0]  sel;
    logic                        stall;
    logic [CNT_BITS-1:0]         stall_cnt;

    fwd_hazard_unit #(
        .REG_BITS(REG_BITS), .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD),
        .LAT_BITS(LAT_BITS), .SEL_BITS(SEL_BITS), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush),
        .sel(sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    // kind: 0 = sel port0, 1 = sel port1, 2 = stall, 3 = stall_cnt
    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against outputs at negedge.
    always @(negedge clk) begin
        chk_t        c;
        logic [15:0] act;
        while (q.size() > 0) begin
            c = q.pop_front();
            case (c.kind)
                0:       act = 16'(sel[1:0]);
                1:       act = 16'(sel[3:2]);
                2:       act = 16'(stall);
                default: act = 16'(stall_cnt);
            endcase
            n_chk++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_val(input int kind, input int val, input string name);
        chk_t c;
        c.kind = kind;
        c.exp  = 16'(val);
        c.name = name;
        q.push_back(c);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ren, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [1:0] fwe, input logic [4:0] f0, input logic [4:0] f1,
                         input logic iv, input logic [4:0] ird, input logic [2:0] ilat,
                         input logic fl, input logic r);
        rd_en       = ren;
        rd_addr     = {a1, a0};
        fwd_we      = fwe;
        fwd_addr    = {f1, f0};
        issue_valid = iv;
        issue_rd    = ird;
        issue_lat   = ilat;
        flush       = fl;
        rst         = r;
    endtask

    initial begin
        int guard;
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
        cyc; cyc;

        // Reset state
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(2, 0, "reset_stall"); expect_val(3, 0, "reset_cnt");
        expect_val(0, 0, "reset_sel0");  expect_val(1, 0, "reset_sel1");
        cyc;

        // Forwarding priority
        drive(2'b01, 5'd5, 5'd0, 2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(0, 1, "fwd_youngest_wins"); expect_val(2, 0, "fwd_no_stall");
        cyc;
        drive(2'b01, 5'd5, 5'd0, 2'b10, 5'd5, 5'd5, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(0, 2, "fwd_stage1_only");
        cyc;
        drive(2'b01, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(0, 0, "fwd_x0_regfile");
        cyc;
        drive(2'b10, 5'd0, 5'd6, 2'b01, 5'd6, 5'd5, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(1, 1, "fwd_port1_stage0"); expect_val(0, 0, "fwd_port0_idle");
        cyc;
        drive(2'b00, 5'd5, 5'd6, 2'b11, 5'd5, 5'd6, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(0, 0, "fwd_rd_en_off0"); expect_val(1, 0, "fwd_rd_en_off1");
        cyc;
        drive(2'b11, 5'd5, 5'd6, 2'b11, 5'd6, 5'd5, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(0, 2, "fwd_cross0"); expect_val(1, 1, "fwd_cross1");
        cyc;

        // Load-use: x7 latency 2, self-read in the issue cycle
        drive(2'b10, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 3'd2, 1'b0, 1'b0);
        expect_val(2, 0, "self_read_no_stall");
        cyc;
        drive(2'b10, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(2, 1, "load_use_t1");
        cyc;
        expect_val(2, 1, "load_use_t2");
        cyc;
        drive(2'b10, 5'd0, 5'd7, 2'b10, 5'd0, 5'd7, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(2, 0, "load_use_t3_free"); expect_val(3, 2, "load_use_cnt");
        expect_val(1, 2, "load_use_fwd");
        cyc;

        // Blocked issue of x9 while x7 is busy
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 3'd2, 1'b0, 1'b0);
        cyc;
        drive(2'b10, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 3'd3, 1'b0, 1'b0);
        expect_val(2, 1, "blocked_stall1");
        cyc;
        expect_val(2, 1, "blocked_stall2");
        cyc;
        drive(2'b11, 5'd9, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(2, 0, "blocked_x9_free"); expect_val(3, 4, "blocked_cnt");
        cyc;
        drive(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(2, 0, "blocked_x9_later");
        cyc;

        // Overwrite: x3 lat 5, two cycles later x3 lat 1
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 3'd5, 1'b0, 1'b0);
        cyc;
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        cyc;
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 3'd1, 1'b0, 1'b0);
        cyc;
        drive(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(2, 1, "overwrite_busy");
        cyc;
        expect_val(2, 0, "overwrite_free"); expect_val(3, 5, "overwrite_cnt");
        cyc;

        // Flush
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 3'd7, 1'b0, 1'b0);
        cyc;
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0);
        cyc;
        drive(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(2, 0, "flush_clears");
        cyc;
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 3'd7, 1'b1, 1'b0);
        cyc;
        drive(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(2, 0, "flush_beats_issue"); expect_val(3, 5, "flush_keeps_cnt");
        cyc;

        // Reset mid-stall
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd8, 3'd7, 1'b0, 1'b0);
        cyc;
        drive(2'b01, 5'd8, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(2, 1, "rst_pre_stall");
        cyc;
        drive(2'b01, 5'd8, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
        expect_val(2, 1, "rst_cycle_stall"); expect_val(3, 6, "rst_cycle_cnt");
        cyc;
        drive(2'b01, 5'd8, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(2, 0, "rst_after_stall"); expect_val(3, 0, "rst_after_cnt");
        cyc;

        // Saturation: three rounds of 7 stalled cycles = 21 stalls
        for (int rnd = 0; rnd < 3; rnd++) begin
            drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd10, 3'd7, 1'b0, 1'b0);
            expect_val(3, (rnd * 7 > 15) ? 15 : rnd * 7, "sat_round_cnt");
            cyc;
            for (int j = 0; j < 7; j++) begin
                drive(2'b01, 5'd10, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
                expect_val(2, 1, "sat_stall");
                cyc;
            end
        end
        drive(2'b01, 5'd10, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        expect_val(2, 0, "sat_free"); expect_val(3, 15, "sat_cnt");
        cyc;

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            cyc;
            guard++;
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the integer pipeline, successor to the fixed two-source, two-port forwarding logic. It has NUM_RD read ports and NUM_FWD forwarding sources with youngest-first priority. It also holds a per-register latency scoreboard that stalls issue while a multi-cycle producer (load, multiply, divide) has not yet produced its result. It sits between decode/issue and EX and drives the EX operand muxes and the pipeline stall line.

## Interface
- REG_BITS, 5, register address width; register 0 is hardwired zero.
- NUM_RD, 2, number of operand read ports.
- NUM_FWD, 2, number of forwarding source stages; index 0 is the youngest (EX/MEM), index NUM_FWD-1 is the oldest.
- LAT_BITS, 3, width of the producer latency field; maximum latency is 2^LAT_BITS-1.
- SEL_BITS, $clog2(NUM_FWD+1), width of each select.
- CNT_BITS, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  NUM_RD  read port p uses a register operand.
- rd_addr  in  NUM_RD*REG_BITS  source register of port p, in slice p.
- fwd_we  in  NUM_FWD  stage k holds a valid register write.
- fwd_addr  in  NUM_FWD*REG_BITS  destination register of stage k.
- issue_valid  in  1  an instruction with a register destination is issuing.
- issue_rd  in  REG_BITS  destination of the issuing instruction.
- issue_lat  in  LAT_BITS  cycles until its result is forwardable; 0 means single-cycle.
- flush  in  1  discard all pending scoreboard entries.
- sel  out  NUM_RD*SEL_BITS  mux select for port p: 0 selects the register file, k+1 selects forwarding stage k.
- stall  out  1  hold issue this cycle.
- stall_cnt  out  CNT_BITS  count of stalled cycles since reset; saturates.

## Operation
- Forwarding (combinational, per port p):
  - If rd_addr[p]==0 or rd_en[p]==0, then sel[p]=0.
  - Otherwise sel[p]=k+1 for the lowest k with fwd_we[k]==1 and fwd_addr[k]==rd_addr[p].
  - If no stage matches, sel[p]=0.
  - The youngest stage always wins when several stages match.
- Scoreboard: one down-counter busy_cnt[r] of LAT_BITS bits per register r in 1..2^REG_BITS-1. Register r is busy when busy_cnt[r]!=0. Register 0 is never busy.
- Stall (combinational): stall=1 when any port p has rd_en[p]=1, rd_addr[p]!=0, and rd_addr[p] is busy.
- Issue acceptance: accept = issue_valid & ~stall. When stall=1, issue_valid is ignored.
- Per-register update each edge, in priority order:
  1. rst or flush: every busy_cnt is cleared to 0.
  2. accept with issue_rd==r, r!=0: busy_cnt[r] loads issue_lat. This overwrites any pending count, because WAW ordering is handled by the younger producer.
  3. Otherwise, if busy_cnt[r]!=0, it decrements by 1.
- An accepted issue with issue_rd==0 has no effect on the scoreboard.
- stall_cnt: increments on every edge where stall=1 and rst=0, and holds at all-ones.
- flush does not clear stall_cnt.

## Timing
- Reset values: every busy_cnt=0, stall_cnt=0. Therefore stall=0 after reset, and sel depends only on the inputs.
- sel and stall have zero latency from their inputs; both are combinational in the same cycle.
- Issue accepted at edge t with latency L:
  - Reads of issue_rd during cycles t+1 .. t+L see stall=1.
  - In cycle t+L+1 the register is free. The result is then expected in a forwarding stage, and sel picks it up.
  - L=0 never stalls.
- A read in the same cycle as the issue of the same register is not stalled by that issue (self-read).
- Simultaneous flush and issue: flush wins, and the entry is not loaded.
- Simultaneous decrement and reload of the same register: the reload wins.
- If rst is asserted mid-stall, stall is 0 in the cycle after the edge.
- A stall that persists across edges is counted once per edge.

## Test plan
- Forward priority: port0 rd_addr=5; fwd_we=2'b11, fwd_addr={5,5} -> sel[0]=1. Then set fwd_we=2'b10 -> sel[0]=2. Then rd_addr=0 with the same stage addresses -> sel[0]=0.
- Load-use: accept issue_rd=7, issue_lat=2 at edge t. Read x7 on port1 in cycles t+1 and t+2 -> stall=1 in both. In cycle t+3 -> stall=0. stall_cnt=2.
- Blocked issue: while x7 is busy, drive issue_valid=1, issue_rd=9, issue_lat=3 with a read of x7 -> x9 never becomes busy. Reads of x9 one cycle after the x7 stall clears -> stall=0.
- Overwrite: issue x3 with lat 5, then two cycles later issue x3 with lat 1 -> x3 busy for exactly 1 further cycle.
- Flush and reset: load x4 lat 7, flush on the next edge -> a read of x4 gives stall=0 the following cycle. Assert rst mid-stall -> stall=0 and stall_cnt=0 after the edge. An issue simultaneous with flush leaves no entry.
- Saturation: with CNT_BITS=4, hold stall for 20 cycles -> stall_cnt=15.
